// File: rtl/dmem_byte_bridge.sv
// Serialises one 32-bit big-endian word access onto a byte-wide acked memory.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject unaligned requests with rsp_err.
module dmem_byte_bridge #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [7:0]        req_wdata [0:3],
  output logic              req_ready,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [7:0]        rsp_rdata [0:3],
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wbyte,
  input  logic [7:0]        mem_rbyte,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  state_t            state;
  logic              we_q;
  logic [ADDR_W-3:0] base_hi;
  logic [7:0]        wdata_q [0:3];
  logic [7:0]        rbuf    [0:3];
  logic [1:0]        lane;
  logic [WAIT_W-1:0] wait_cnt;
  logic              misalign;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:ADDR_W], req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = |req_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '{default: '0};
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wbyte <= '0;
      we_q      <= 1'b0;
      base_hi   <= '0;
      wdata_q   <= '{default: '0};
      rbuf      <= '{default: '0};
      lane      <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            base_hi   <= req_addr[ADDR_W-1:2];
            wdata_q   <= req_wdata;
            lane      <= '0;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (misalign) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= XFER;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wbyte <= req_wdata[0];
            end
          end
        end

        XFER: begin
          // An ack arriving on the final allowed wait cycle still completes the byte.
          if (mem_ack) begin
            wait_cnt <= '0;
            if (!we_q) rbuf[lane] <= mem_rbyte;
            if (lane == 2'd3) begin
              state     <= RESP;
              mem_en    <= 1'b0;
              mem_we    <= 1'b0;
              rsp_valid <= 1'b1;
              if (!we_q) rsp_rdata <= '{rbuf[0], rbuf[1], rbuf[2], mem_rbyte};
            end else begin
              lane      <= lane + 2'd1;
              mem_addr  <= {base_hi, lane + 2'd1};
              mem_wbyte <= wdata_q[lane + 2'd1];
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// Directed bench for dmem_byte_bridge with a byte memory model that can stall or hang a lane.
module tb_dmem_byte_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata [0:3];
  logic        req_ready;
  logic        busy;
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata [0:3];
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wbyte;
  logic [7:0]  mem_rbyte;
  logic        mem_ack;

  always #5 clk = ~clk;

  dmem_byte_bridge #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wbyte(mem_wbyte),
    .mem_rbyte(mem_rbyte), .mem_ack(mem_ack)
  );

  // byte memory model: initialised to addr ^ 0xA5
  logic [7:0] mem [0:255];
  logic       init_mem;
  int         hang_lane;
  int         stall_lane;
  int         stall_n;
  int         stall_cnt;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (mem_en && mem_ack && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wbyte;
    end
  end

  always @(negedge clk) begin
    mem_rbyte <= mem[mem_addr[7:0]];
    if (!mem_en) begin
      mem_ack   <= 1'b0;
      stall_cnt <= 0;
    end else if (int'(mem_addr[1:0]) == hang_lane) begin
      mem_ack <= 1'b0;
    end else if (int'(mem_addr[1:0]) == stall_lane && stall_cnt < stall_n) begin
      mem_ack   <= 1'b0;
      stall_cnt <= stall_cnt + 1;
    end else begin
      mem_ack   <= 1'b1;
      stall_cnt <= 0;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  int          lat, en_cnt, en_at1;
  logic        err_seen, busy_mid, post_valid, post_ready;
  logic [31:0] rdata_seen, log_addr, log_data;

  function automatic logic [31:0] rdata_word();
    return {rsp_rdata[0], rsp_rdata[1], rsp_rdata[2], rsp_rdata[3]};
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // lat = cycles from accept edge to rsp_valid (T+lat); 99 when no response in budget
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata[0] = wd[31:24];
    req_wdata[1] = wd[23:16];
    req_wdata[2] = wd[15:8];
    req_wdata[3] = wd[7:0];
    @(posedge clk);
    lat = 99; en_cnt = 0; en_at1 = 0; err_seen = 1'b0; rdata_seen = '0;
    log_addr = '0; log_data = '0; busy_mid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (n == 1) busy_mid = busy;
      if (mem_en) en_cnt++;
      if (mem_en && mem_addr[1:0] == 2'd1) en_at1++;
      if (mem_en && mem_ack) begin
        log_addr = {log_addr[23:0], mem_addr[7:0]};
        log_data = {log_data[23:0], mem_wbyte};
      end
      if (rsp_valid) begin
        lat        = n;
        err_seen   = rsp_err;
        rdata_seen = rdata_word();
        break;
      end
    end
    @(negedge clk);
    #1;
    post_valid = rsp_valid;
    post_ready = req_ready;
  endtask

  int seen_rsp;

  initial begin
    rst = 1'b1; init_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '{default: '0};
    hang_lane = -1; stall_lane = -1; stall_n = 0;
    repeat (2) @(posedge clk);
    init_mem = 1'b0;
    @(negedge clk); #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_memen", {31'd0, mem_en},    32'd0);
    check("rst_addr",  {16'd0, mem_addr},  32'd0);
    check("rst_rdata", rdata_word(),       32'd0);
    rst = 1'b0;

    // zero-wait store
    run_req(1'b1, 32'h0000_0010, 32'h1122_3344);
    check("st_lat",   lat, 5);
    check("st_err",   {31'd0, err_seen}, 32'd0);
    check("st_en",    en_cnt, 4);
    check("st_addrs", log_addr, 32'h1011_1213);
    check("st_bytes", log_data, 32'h1122_3344);
    check("st_busy",  {31'd0, busy_mid}, 32'd1);
    check("st_pulse", {31'd0, post_valid}, 32'd0);
    check("st_ready", {31'd0, post_ready}, 32'd1);
    check("st_mem",   mem_word(16), 32'h1122_3344);
    check("st_rdata_hold", rdata_seen, 32'd0);

    // zero-wait load of the same word
    run_req(1'b0, 32'h0000_0010, 32'h0);
    check("ld_lat",   lat, 5);
    check("ld_err",   {31'd0, err_seen}, 32'd0);
    check("ld_data",  rdata_seen, 32'h1122_3344);
    check("ld_addrs", log_addr, 32'h1011_1213);

    // two wait cycles on lane 2
    stall_lane = 2; stall_n = 2;
    run_req(1'b0, 32'h0000_0041, 32'h0);
    stall_lane = -1; stall_n = 0;
    check("wt_lat",  lat, 7);
    check("wt_err",  {31'd0, err_seen}, 32'd0);
    check("wt_data", rdata_seen, 32'hE5E4_E7E6);

    // lane 1 never acked: timeout after 4 cycles on base+1
    hang_lane = 1;
    run_req(1'b0, 32'h0000_0010, 32'h0);
    hang_lane = -1;
    check("to_lat",   lat, 6);
    check("to_err",   {31'd0, err_seen}, 32'd1);
    check("to_en",    en_cnt, 5);
    check("to_en_b1", en_at1, 4);
    check("to_rdata", rdata_seen, 32'hE5E4_E7E6);
    check("to_ready", {31'd0, post_ready}, 32'd1);

    // reset asserted while lane 2 of a store is on the bus
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020;
    req_wdata[0] = 8'hDE; req_wdata[1] = 8'hAD; req_wdata[2] = 8'hBE; req_wdata[3] = 8'hEF;
    @(posedge clk);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (mem_en && mem_addr[1:0] == 2'd2) begin
        lat = n;
        break;
      end
    end
    check("rs_lane2_at", lat, 3);
    rst = 1'b1;
    #1;
    check("rs_memen", {31'd0, mem_en},    32'd0);
    check("rs_busy",  {31'd0, busy},      32'd0);
    check("rs_ready", {31'd0, req_ready}, 32'd1);
    check("rs_valid", {31'd0, rsp_valid}, 32'd0);
    check("rs_rdata", rdata_word(),       32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_rsp = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (rsp_valid) seen_rsp++;
    end
    check("rs_no_rsp", seen_rsp, 0);
    check("rs_mem", mem_word(32), 32'hDEAD_8786);

    // unaligned store to 0x13
    run_req(1'b1, 32'h0000_0013, 32'h5566_7788);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("ma_lat", lat, 1);
    check("ma_err", {31'd0, err_seen}, 32'd1);
    check("ma_en",  en_cnt, 0);
    check("ma_mem", mem_word(16), 32'h1122_3344);
`else
    check("ma_lat",   lat, 5);
    check("ma_err",   {31'd0, err_seen}, 32'd0);
    check("ma_addrs", log_addr, 32'h1011_1213);
    check("ma_mem",   mem_word(16), 32'h5566_7788);
`endif

    run_req(1'b0, 32'h0000_0010, 32'h0);
    check("fin_lat", lat, 5);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("fin_data", rdata_seen, 32'h1122_3344);
`else
    check("fin_data", rdata_seen, 32'h5566_7788);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
